isqrt_sched: RTL and testbench
==============================

Name: isqrt_sched

Overview:
- Controller/arbiter that shares one iterative integer-square-root engine between NREQ requesters.
- Round-robin grant, latches the radicand, issues a one-cycle start to the engine and waits for done. Returns floor(sqrt) tagged with the requester ID over a valid/ready response channel.
- Sits between the switch/button front-ends and the shared isqrt datapath; the display logic consumes its response channel.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 14, radicand width
- RW, 7, root width; must equal ceil(DW/2)
- IDW, 2, requester-ID width; must equal clog2(NREQ)
- TMO_CYC, 255, watchdog limit in cycles (used only with ISQRT_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*DW  radicands; requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant/accept strobe
- eng_start  out  1  one-cycle start pulse to engine
- eng_d  out  DW  radicand to engine; held stable from start until done
- eng_done  in  1  engine completion pulse
- eng_root  in  RW  engine result, valid while eng_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_id  out  IDW  requester index of the response
- rsp_root  out  RW  floor(sqrt(radicand))
- rsp_err  out  1  watchdog abort flag (tied 0 without the feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr pointer=NREQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, eng_start, eng_d, rsp_valid, rsp_id, rsp_root, rsp_err.
  - Reset mid-operation abandons the job; the engine shares rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first asserted index searching from ptr+1 with wrap-around.
  - req_ready[g]=1 for exactly that cycle, combinationally with req_valid. Handshake completes in the same cycle.
  - Latch req_data[g] into eng_d and g into rsp_id; ptr<=g; next state ISSUE.
  - No requests: stay in IDLE, req_ready=0.
- ISSUE: eng_start=1 for one cycle; next state WAIT.
- WAIT:
  - eng_start=0; eng_d held.
  - On eng_done=1: rsp_root<=eng_root, rsp_err<=0, next state RESP.
  - eng_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_root and rsp_err stay stable until rsp_ready=1.
  - On handshake: rsp_valid deasserts next cycle and state returns to IDLE.
  - The next grant happens in the IDLE cycle after that.
- Latency: grant at cycle 0, eng_start at cycle 1, engine done at cycle 1+L, rsp_valid at cycle 2+L.
- Throughput: one job in flight; minimum 4+L cycles per job with rsp_ready held high.
- Fairness: a requester that deasserts req_valid before its grant loses nothing; there is no request queue. A continuously requesting set is served in strict rotation.
- Arithmetic: no arithmetic on the data path. The scheduler passes eng_root through unchanged; radicand 0 must yield root 0.

Optional Feature:
- Macro ISQRT_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit+ watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMO_CYC without eng_done: rsp_root<=0, rsp_err<=1, go to RESP.
  - eng_done and expiry in the same cycle: done wins, rsp_err=0.
  - A late eng_done after abort is ignored.
- Undefined: no counter; rsp_err is constant 0; WAIT lasts indefinitely.

Decomposition:
- Package isqrt_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - default DW/RW/NREQ constants
  - clog2 helper for IDW
- One sub-module, isqrt_rr_arb: combinational round-robin pick from req_valid and ptr. Outputs a one-hot grant and encoded index.
- FSM, latches and watchdog stay in isqrt_sched.

Test Plan:
- Single request: req_valid=0001, req_data[0]=144, engine model L=13 returning 12 → req_ready=0001 at cycle 0; eng_start at cycle 1 with eng_d=144; rsp_valid at cycle 15 with rsp_id=0, rsp_root=12, rsp_err=0.
- All four requesting continuously (radicands 0, 1, 2, 16383), rsp_ready=1 → grants in order 0,1,2,3,0. Roots 0, 1, 1, 127 with matching IDs.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp fields stable and no new req_ready. Release → one handshake, then next grant two cycles later.
- Stray eng_done pulses in IDLE and during ISSUE → no state change and no rsp_valid.
- Async reset asserted in WAIT → all outputs 0 immediately. After release, a request from requester 2 is granted with ptr restarting at requester 0 priority.
- ISQRT_SCHED_TIMEOUT_EN, TMO_CYC=20, engine never done → rsp_valid with rsp_err=1, rsp_root=0. Repeat with done exactly at expiry → rsp_err=0 with a valid root.

Source files
------------

// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared state type, default sizes and clog2 helper for the isqrt scheduler
package isqrt_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DW      = 14;
  localparam int DEF_RW      = 7;
  localparam int DEF_TMO_CYC = 255;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/isqrt_rr_arb.sv
// rtl/isqrt_rr_arb.sv - combinational round-robin pick, searching upward from ptr+1 with wrap
module isqrt_rr_arb
  import isqrt_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int              cand;
  logic [NREQ-1:0] rot;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    rot     = '0;
    // k runs 1..NREQ so the last granted index is checked last
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      rot  = req_valid_i >> cand;
      if (!any_o && rot[0]) begin
        any_o   = 1'b1;
        grant_o = NREQ'(1) << cand;
        idx_o   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/isqrt_sched.sv
// rtl/isqrt_sched.sv - shares one iterative isqrt engine between NREQ requesters
// Optional watchdog abort: define ISQRT_SCHED_TIMEOUT_EN.
module isqrt_sched
  import isqrt_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int RW   = DEF_RW,
  parameter int IDW  = clog2(NREQ)
`ifdef ISQRT_SCHED_TIMEOUT_EN
  , parameter int TMO_CYC = DEF_TMO_CYC
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             eng_start,
  output logic [DW-1:0]    eng_d,
  input  logic             eng_done,
  input  logic [RW-1:0]    eng_root,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [RW-1:0]    rsp_root,
  output logic             rsp_err
);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic            hold_q;
  logic            eng_start_q;
  logic [DW-1:0]   eng_d_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [RW-1:0]   rsp_root_q;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            can_grant;

`ifdef ISQRT_SCHED_TIMEOUT_EN
  localparam int CW = (clog2(TMO_CYC + 1) > 8) ? clog2(TMO_CYC + 1) : 8;
  logic [CW-1:0] wdog_q;
  logic          rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  isqrt_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .idx_o       (arb_idx),
    .any_o       (arb_any)
  );

  // hold_q spends one idle cycle after each response before granting again
  assign can_grant = rst_n && (state_q == IDLE) && !hold_q;
  assign req_ready = can_grant ? arb_grant : '0;
  assign eng_start = eng_start_q;
  assign eng_d     = eng_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_root  = rsp_root_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      hold_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_root_q  <= '0;
`ifdef ISQRT_SCHED_TIMEOUT_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      hold_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (can_grant && arb_any) begin
            eng_d_q     <= req_data[arb_idx*DW +: DW];
            rsp_id_q    <= arb_idx;
            ptr_q       <= arb_idx;
            eng_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef ISQRT_SCHED_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        WAIT: begin
          if (eng_done) begin
            rsp_root_q  <= eng_root;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef ISQRT_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
`ifdef ISQRT_SCHED_TIMEOUT_EN
          else if (wdog_q == CW'(TMO_CYC)) begin
            rsp_root_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            hold_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_sched.sv
// tb/tb_isqrt_sched.sv - scoreboard bench for isqrt_sched with a latency-programmable engine model
module tb_isqrt_sched;

  localparam int NREQ = 4;
  localparam int DW   = 14;
  localparam int RW   = 7;
  localparam int IDW  = 2;

  typedef struct {
    int id;
    int root;
    int err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [DW-1:0]     rd [NREQ];
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              eng_start;
  logic [DW-1:0]     eng_d;
  logic              eng_done;
  logic              eng_done_m = 1'b0;
  logic              eng_done_s = 1'b0;
  logic [RW-1:0]     eng_root = 7'h5A;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [RW-1:0]     rsp_root;
  logic              rsp_err;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_now = 0;
  int   epoch = 0;
  int   eng_lat = 13;
  int   exp_abort = 0;
  int   gnt_cnt = 0;
  int   last_gnt = 0;
  bit   gnt_seen = 1'b0;
  bit   chk_period = 1'b0;
  int   exp_gnt[$];
  exp_t sb[$];

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};
  assign eng_done = eng_done_m | eng_done_s;

  isqrt_sched #(
    .NREQ (NREQ),
    .DW   (DW),
    .RW   (RW),
    .IDW  (IDW)
`ifdef ISQRT_SCHED_TIMEOUT_EN
    , .TMO_CYC (20)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_d     (eng_d),
    .eng_done  (eng_done),
    .eng_root  (eng_root),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now++;

  function automatic int isqrt_ref(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: done is high for the whole cycle start+L
  always begin : engine
    int ep;
    int r;
    @(negedge clk);
    if (rst_n && eng_start) begin
      ep = epoch;
      r  = isqrt_ref(int'(eng_d));
      if (eng_lat > 0) begin
        repeat (eng_lat) @(negedge clk);
        if (ep == epoch) begin
          eng_root   = RW'(r);
          eng_done_m = 1'b1;
          @(negedge clk);
          eng_done_m = 1'b0;
          eng_root   = 7'h5A;
        end
      end
    end
  end

  // Grant / response monitor feeding and draining the scoreboard
  always begin : monitor
    int   g;
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) begin
          check_val("gnt_unexpected", 32'(req_ready), 0);
        end else begin
          g = exp_gnt.pop_front();
          check_val("gnt_onehot", 32'(req_ready), 32'(1 << g));
          if (chk_period && gnt_seen) check_val("gnt_period", cyc_now - last_gnt, 17);
          gnt_seen = 1'b1;
          last_gnt = cyc_now;
          gnt_cnt++;
          sb.push_back('{g, exp_abort ? 0 : isqrt_ref(int'(rd[g])), exp_abort});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_val("rsp_id", 32'(rsp_id), e.id);
          check_val("rsp_root", 32'(rsp_root), e.root);
          check_val("rsp_err", 32'(rsp_err), e.err);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    epoch++;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    eng_done_s = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    exp_gnt.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || rsp_valid) && t < 200) begin
      @(negedge clk);
      #3;
      t++;
    end
    check_val(tag, sb.size(), 0);
  endtask

  task automatic run_one(input int g, input int d, input int exp_lat, input bit stray, input string tag);
    int cyc;
    @(negedge clk);
    rd[g]     = DW'(d);
    req_valid = NREQ'(1 << g);
    exp_gnt.push_back(g);
    #3;
    check_val({tag, "_ready"}, 32'(req_ready), 32'(1 << g));
    @(negedge clk);
    req_valid  = '0;
    eng_done_s = stray;
    #3;
    cyc = 1;
    check_val({tag, "_start"}, 32'(eng_start), 1);
    check_val({tag, "_eng_d"}, 32'(eng_d), d);
    @(negedge clk);
    eng_done_s = 1'b0;
    #3;
    cyc = 2;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    check_val({tag, "_latency"}, cyc, exp_lat);
    @(negedge clk);
    #3;
    check_val({tag, "_rsp_drop"}, 32'(rsp_valid), 0);
  endtask

  initial begin : main
    int t;
    int bad_stable;
    int bad_rdy;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;

    #2 rst_n = 1'b0;
    #2;
    check_val("rst_req_ready", 32'(req_ready), 0);
    check_val("rst_eng_start", 32'(eng_start), 0);
    check_val("rst_eng_d", 32'(eng_d), 0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 0);
    check_val("rst_rsp_id", 32'(rsp_id), 0);
    check_val("rst_rsp_root", 32'(rsp_root), 0);
    check_val("rst_rsp_err", 32'(rsp_err), 0);
    do_reset();

    run_one(0, 144, 15, 1'b0, "single");

    // Continuous requests from all four: strict rotation 0,1,2,3,0
    do_reset();
    rd[0] = 14'd0; rd[1] = 14'd1; rd[2] = 14'd2; rd[3] = 14'd16383;
    exp_gnt = '{0, 1, 2, 3, 0};
    gnt_cnt = 0; gnt_seen = 1'b0; chk_period = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    t = 0;
    while (gnt_cnt < 5 && t < 300) begin
      @(negedge clk);
      #3;
      t++;
    end
    check_val("rr_grants", gnt_cnt, 5);
    @(negedge clk);
    req_valid  = '0;
    chk_period = 1'b0;
    wait_drain("rr_drain");

    // Backpressure: response fields hold, no grant until after release
    do_reset();
    rd[1] = 14'd400; rd[2] = 14'd10000;
    rsp_ready = 1'b0;
    exp_gnt.push_back(1);
    @(negedge clk);
    req_valid = 4'b0110;
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    check_val("bp_rsp_seen", 32'(rsp_valid), 1);
    exp_gnt.push_back(2);
    bad_stable = 0;
    bad_rdy    = 0;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_root !== 7'd20 || rsp_err !== 1'b0) bad_stable++;
      if (req_ready !== '0) bad_rdy++;
    end
    check_val("bp_stable", bad_stable, 0);
    check_val("bp_no_grant", bad_rdy, 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #3;
    check_val("bp_gap_ready", 32'(req_ready), 0);
    check_val("bp_rsp_drop", 32'(rsp_valid), 0);
    @(negedge clk);
    #3;
    check_val("bp_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_drain("bp_drain");

    // Stray done in IDLE, then stray done during ISSUE
    @(negedge clk);
    eng_done_s = 1'b1;
    @(negedge clk);
    eng_done_s = 1'b0;
    #3;
    check_val("stray_idle_rsp", 32'(rsp_valid), 0);
    check_val("stray_idle_start", 32'(eng_start), 0);
    run_one(3, 169, 15, 1'b1, "stray_issue");

    // Async reset during WAIT, then requesters 2 and 3 compete
    rd[2] = 14'd9999;
    exp_gnt.push_back(2);
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b1100;
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    epoch++;
    #1;
    check_val("arst_req_ready", 32'(req_ready), 0);
    check_val("arst_eng_d", 32'(eng_d), 0);
    check_val("arst_rsp_id", 32'(rsp_id), 0);
    check_val("arst_rsp_root", 32'(rsp_root), 0);
    check_val("arst_rsp_valid", 32'(rsp_valid), 0);
    repeat (16) @(negedge clk);
    sb.delete();
    exp_gnt.delete();
    rd[3] = 14'd50;
    exp_gnt.push_back(2);
    rst_n = 1'b1;
    #3;
    check_val("arst_regrant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_drain("arst_drain");

`ifdef ISQRT_SCHED_TIMEOUT_EN
    eng_lat   = 0;
    exp_abort = 1;
    run_one(1, 900, 23, 1'b0, "tmo_abort");
    eng_lat   = 21;
    exp_abort = 0;
    run_one(2, 900, 23, 1'b0, "tmo_done_wins");
    eng_lat   = 13;
`endif

    check_val("gnt_all_seen", exp_gnt.size(), 0);
    check_val("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL sim_timeout: got %0d cycles expected completion", cyc_now);
    $fatal(1, "simulation time limit");
  end

endmodule
